// File: rtl/fp_int_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_int_acc_seq
//  Description : Sequence accumulator for the FP-INT MAC datapath. Aligns a
//                stream of sign-magnitude mantissas to a block exponent and
//                accumulates them into a saturating two's-complement register.
//                Two-stage pipeline (align, add) with a sequencing FSM and a
//                valid/ready result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_int_acc_seq #(
  parameter int MAN_W = 14,
  parameter int EXP_W = 5,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [EXP_W-1:0] exp_set,
  input  logic [ACC_W-1:0] acc_init,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [MAN_W-1:0] man_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             overflow,
  output logic             busy
);

  // A mantissa shifted left by the largest possible exponent difference
  // must fit without loss before the clamp decision is made.
  localparam int SHIFT_W = MAN_W + (1 << EXP_W);
  // Aligned magnitudes are clamped to 2^(ACC_W-1)-1, so ACC_W-1 bits suffice.
  localparam int MAG_W   = ACC_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [EXP_W-1:0] exp_reg;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic             ovf_reg;
  logic             out_valid_reg;

  logic             s1_valid;
  logic             s1_sign;
  logic [MAG_W-1:0] s1_mag;

  logic             accept;
  logic             start_idle;

  logic [EXP_W:0]   diff;
  logic [EXP_W:0]   rshift;
  logic [SHIFT_W-1:0] lshifted;
  logic             lshift_big;
  logic [MAG_W-1:0] align_mag;
  logic             align_clamp;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_sat;
  logic             add_clamp;

  assign in_ready   = (state == RUN);
  assign accept     = in_valid && in_ready;
  assign start_idle = start && (state == IDLE);

  assign out_valid  = out_valid_reg;
  assign acc_out    = acc;
  assign exp_out    = exp_reg;
  assign overflow   = ovf_reg;
  assign busy       = (state != IDLE);

  // Detect a left-shifted magnitude that no longer fits below 2^(ACC_W-1).
  generate
    if (SHIFT_W > MAG_W) begin : g_clamp_wide
      assign lshift_big = |lshifted[SHIFT_W-1:MAG_W];
    end else begin : g_clamp_narrow
      assign lshift_big = 1'b0;
    end
  endgenerate

  // Stage-1 alignment: shift the term magnitude onto the block exponent.
  always_comb begin
    diff        = {1'b0, exp_in} - {1'b0, exp_reg};
    rshift      = $unsigned(-$signed(diff));
    lshifted    = SHIFT_W'(man_in) << diff[EXP_W-1:0];
    align_mag   = '0;
    align_clamp = 1'b0;
    if (!diff[EXP_W]) begin
      if (lshift_big) begin
        align_mag   = {MAG_W{1'b1}};
        align_clamp = 1'b1;
      end else begin
        align_mag   = lshifted[MAG_W-1:0];
      end
    end else if (32'(rshift) < MAN_W) begin
      // Bits shifted out on the right are simply truncated.
      align_mag = MAG_W'(man_in >> rshift);
    end
  end

  // Stage-2 add/subtract with one guard bit, then saturate to ACC_W.
  always_comb begin
    if (s1_sign) begin
      sum = {acc[ACC_W-1], acc} - {2'b00, s1_mag};
    end else begin
      sum = {acc[ACC_W-1], acc} + {2'b00, s1_mag};
    end
    add_clamp = (sum[ACC_W] != sum[ACC_W-1]);
    if (!add_clamp) begin
      sum_sat = sum[ACC_W-1:0];
    end else if (sum[ACC_W]) begin
      sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Sequencing FSM next-state logic; clear overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:     if (accept && (count == LEN_W'(1))) state_next = DRAIN;
      DRAIN:   if (!s1_valid) state_next = DONE;
      DONE:    if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // State register; out_valid is registered so it is high exactly in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      state         <= state_next;
      out_valid_reg <= (state_next == DONE);
    end
  end

  // Stage-1 pipeline register holding the aligned term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else begin
      s1_valid <= accept && !clear;
      if (accept) begin
        s1_sign <= sign_in;
        s1_mag  <= align_mag;
      end
    end
  end

  // Sequence context: block exponent, accumulator, term count, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_reg <= '0;
      acc     <= '0;
      count   <= '0;
      ovf_reg <= 1'b0;
    end else if (clear) begin
      // Abort drops the in-flight term; acc and overflow keep their values.
      count   <= '0;
    end else if (start_idle) begin
      exp_reg <= exp_set;
      acc     <= acc_init;
      count   <= len;
      ovf_reg <= 1'b0;
    end else begin
      if (s1_valid) begin
        acc <= sum_sat;
      end
      if (accept) begin
        count <= count - LEN_W'(1);
      end
      if ((accept && align_clamp) || (s1_valid && add_clamp)) begin
        ovf_reg <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_int_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_int_acc_seq
//  Description : Self-checking bench for fp_int_acc_seq: directed vector table,
//                abort/reset sequences and randomized sequences against an
//                integer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_int_acc_seq;

  localparam int MAN_W = 14;
  localparam int EXP_W = 5;
  localparam int ACC_W = 32;
  localparam int LEN_W = 8;
  localparam int MAXT  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             clear;
  logic [EXP_W-1:0] exp_set;
  logic [ACC_W-1:0] acc_init;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             sign_in;
  logic [EXP_W-1:0] exp_in;
  logic [MAN_W-1:0] man_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [EXP_W-1:0] exp_out;
  logic             overflow;
  logic             busy;

  fp_int_acc_seq #(
    .MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .exp_set(exp_set), .acc_init(acc_init), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .exp_out(exp_out),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  logic             t_sign [MAXT];
  logic [EXP_W-1:0] t_exp  [MAXT];
  logic [MAN_W-1:0] t_man  [MAXT];

  typedef struct {
    logic [4:0]        es;
    logic [31:0]       init;
    int                n;
    logic [3:0]        sg;
    logic [3:0][4:0]   ex;
    logic [3:0][13:0]  mn;
    logic [31:0]       exp_acc;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer arithmetic on the alignment and saturation rules.
  function automatic void model(input logic [4:0] es, input logic [31:0] init, input int n,
                                output logic [31:0] r, output logic o);
    longint a, mag, maxp, minn;
    int d;
    maxp = (64'sd1 <<< 31) - 1;
    minn = -(64'sd1 <<< 31);
    a = longint'(signed'(init));
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = int'(t_exp[i]) - int'(es);
      if (d >= 0) begin
        mag = longint'(t_man[i]) << d;
        if (mag > maxp) begin mag = maxp; o = 1'b1; end
      end else if (-d >= MAN_W) begin
        mag = 0;
      end else begin
        mag = longint'(t_man[i]) >> (-d);
      end
      a = t_sign[i] ? a - mag : a + mag;
      if (a > maxp) begin a = maxp; o = 1'b1; end
      else if (a < minn) begin a = minn; o = 1'b1; end
    end
    r = a[31:0];
  endfunction

  // Drive one full sequence from start through the output handshake.
  task automatic run_seq(input logic [4:0] es, input logic [31:0] init, input int n,
                         input bit gaps, input int hold,
                         input logic [31:0] exp_acc, input logic exp_ovf, input string tag);
    int i, last_edge, budget;
    bit took;
    start = 1'b1; exp_set = es; acc_init = init; len = LEN_W'(n);
    step();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    last_edge = edge_cnt;
    i = 0; budget = 0;
    while (i < n && budget < 200) begin
      sign_in = t_sign[i]; exp_in = t_exp[i]; man_in = t_man[i];
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      took = in_valid && in_ready;
      step();
      if (took) begin i++; last_edge = edge_cnt; end
      budget++;
    end
    in_valid = 1'b0;
    check({tag, " terms accepted"}, i, n);
    check({tag, " in_ready after last"}, in_ready, 0);
    budget = 0;
    while (!out_valid && budget < 10) begin step(); budget++; end
    check({tag, " out_valid latency"}, edge_cnt - last_edge, (n == 0) ? 0 : 2);
    check({tag, " acc_out"}, acc_out, exp_acc);
    check({tag, " overflow"}, overflow, exp_ovf);
    check({tag, " exp_out"}, exp_out, es);
    for (int k = 0; k < hold; k++) begin
      start = 1'b1; exp_set = ~es; acc_init = ~init; len = '0;
      step();
      start = 1'b0;
      check({tag, " hold out_valid"}, out_valid, 1);
      check({tag, " hold acc_out"}, acc_out, exp_acc);
      check({tag, " hold exp_out"}, exp_out, es);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, busy, 0);
    check({tag, " out_valid dropped"}, out_valid, 0);
  endtask

  logic [31:0] m_acc;
  logic        m_ovf;
  logic [4:0]  r_es;
  logic [31:0] r_init;
  int          r_n;

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; exp_set = '0; acc_init = '0; len = '0;
    in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; man_in = '0; out_ready = 1'b0;

    vecs[0] = '{5'd10, 32'd0,        3, 4'b0100, {5'd0, 5'd8, 5'd12, 5'd10},
                {14'd0, 14'd40, 14'd3, 14'd100}, 32'd102, 1'b0};
    vecs[1] = '{5'd7,  32'h0000_1234, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},
                {14'd0, 14'd0, 14'd0, 14'd0}, 32'h0000_1234, 1'b0};
    vecs[2] = '{5'd0,  32'd0,        2, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd31},
                {14'd0, 14'd0, 14'd1, 14'd1}, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{5'd0,  32'h8000_0000, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0},
                {14'd0, 14'd0, 14'd0, 14'd1}, 32'h8000_0000, 1'b1};
    vecs[4] = '{5'd31, 32'd0,        1, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},
                {14'd0, 14'd0, 14'd0, 14'h3FFF}, 32'd0, 1'b0};
    vecs[5] = '{5'd2,  32'd0,        1, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},
                {14'd0, 14'd0, 14'd0, 14'd7}, 32'd1, 1'b0};
    vecs[6] = '{5'd5,  32'hFFFF_FFCE, 2, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd5},
                {14'd0, 14'd0, 14'd3, 14'd20}, 32'hFFFF_FFD6, 1'b0};
    vecs[7] = '{5'd3,  32'h7FFF_FFF0, 2, 4'b0010, {5'd0, 5'd0, 5'd3, 5'd3},
                {14'd0, 14'd0, 14'd5, 14'h20}, 32'h7FFF_FFFA, 1'b1};

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset acc_out", acc_out, 0);
    check("reset exp_out", exp_out, 0);
    check("reset overflow", overflow, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    step();

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      for (int t = 0; t < 4; t++) begin
        t_sign[t] = vecs[v].sg[t];
        t_exp[t]  = vecs[v].ex[t];
        t_man[t]  = vecs[v].mn[t];
      end
      run_seq(vecs[v].es, vecs[v].init, vecs[v].n, (v % 2) == 1, (v == 0) ? 5 : v % 3,
              vecs[v].exp_acc, vecs[v].exp_ovf, $sformatf("vec%0d", v));
      step();
    end

    // Abort with clear after one accepted term.
    start = 1'b1; exp_set = 5'd0; acc_init = 32'd100; len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; sign_in = 1'b0; exp_in = 5'd0; man_in = 14'd5;
    step();
    in_valid = 1'b0;
    step();
    check("clear pre in_ready", in_ready, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear busy", busy, 0);
    check("clear in_ready", in_ready, 0);
    check("clear out_valid", out_valid, 0);
    check("clear acc hold", acc_out, 105);
    check("clear overflow", overflow, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("clear out_valid stays", out_valid, 0);
    end

    // Asynchronous reset in the middle of a sequence.
    start = 1'b1; exp_set = 5'd0; acc_init = 32'd9; len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; sign_in = 1'b0; exp_in = 5'd31; man_in = 14'd1;
    step();
    step();
    in_valid = 1'b0;
    step();
    check("pre-rst overflow", overflow, 1);
    rst = 1'b1;
    #2;
    check("rst acc_out", acc_out, 0);
    check("rst exp_out", exp_out, 0);
    check("rst overflow", overflow, 0);
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;
    step();

    // Randomized sequences against the reference model.
    for (int s = 0; s < 24; s++) begin
      r_es   = 5'($urandom_range(0, 31));
      r_init = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4000));
      r_n    = $urandom_range(0, 12);
      for (int t = 0; t < r_n; t++) begin
        t_sign[t] = 1'($urandom_range(0, 1));
        t_exp[t]  = 5'($urandom_range(0, 31));
        t_man[t]  = 14'($urandom);
      end
      model(r_es, r_init, r_n, m_acc, m_ovf);
      run_seq(r_es, r_init, r_n, 1'b1, $urandom_range(0, 5), m_acc, m_ovf,
              $sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
